// File: rtl/vga_pixel_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_fetch_if
//  Description : Pipelined read-master bus between the pixel fetcher and memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_pixel_fetch_if #(
    parameter int ADDR_W = 24
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_waitrequest;
    logic [31:0]       mem_readdata;
    logic              mem_readdatavalid;

    modport master (
        output mem_address, mem_read,
        input  mem_waitrequest, mem_readdata, mem_readdatavalid
    );

    modport slave (
        input  mem_address, mem_read,
        output mem_waitrequest, mem_readdata, mem_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_fetch
//  Description : Streams a linear framebuffer into a show-ahead pixel FIFO
//                feeding the VGA timing driver; restarts on each vsync fall.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_fetch #(
    parameter int                H_ACT     = 640,
    parameter int                V_ACT     = 480,
    parameter int                FIFO_AW   = 6,
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] FB_BASE   = '0,
    parameter logic [29:0]       UFLOW_RGB = 30'h0
) (
    input  logic              clk27,
    input  logic              rst27,
    input  logic              vga_vs,
    input  logic              request,
    output logic [9:0]        r,
    output logic [9:0]        g,
    output logic [9:0]        b,
    vga_pixel_fetch_if.master mem,
    output logic              underflow,
    input  logic              underflow_clr
);
    localparam int c_DEPTH = 2**FIFO_AW;
    localparam int c_FRAME = H_ACT * V_ACT;
    localparam int c_IW    = $clog2(c_FRAME + 1);
    localparam int c_CW    = FIFO_AW + 1;
    localparam logic [c_IW-1:0] c_LAST    = c_IW'(c_FRAME - 1);
    localparam logic [c_CW:0]   c_DEPTH_W = (c_CW+1)'(c_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_vs_d;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_IW-1:0]     r_issued;
    logic [c_CW-1:0]     r_outst;
    logic [c_CW-1:0]     r_discard;
    logic [c_CW-1:0]     r_count;
    logic [FIFO_AW-1:0]  r_wr_ptr;
    logic [FIFO_AW-1:0]  r_rd_ptr;
    logic [29:0]         r_fifo [c_DEPTH];
    logic                r_underflow;

    logic                w_vs_fall;
    logic                w_mem_read;
    logic                w_accept;
    logic                w_beat;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic [c_CW:0]       w_inflight;
    logic [c_CW-1:0]     w_outst_nxt;
    logic                w_unused;

    assign w_vs_fall  = r_vs_d & ~vga_vs;
    assign w_empty    = (r_count == '0);
    assign w_accept   = w_mem_read & ~mem.mem_waitrequest;
    assign w_beat     = mem.mem_readdatavalid;
    assign w_push     = w_beat & (r_discard == '0);
    assign w_pop      = request & ~w_empty;
    // Words already in the FIFO plus words still in flight bound the issue window.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outst};
    assign w_unused   = &{1'b0, mem.mem_readdata[31:30]};

    always_ff @(posedge clk27) begin
        if (rst27) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_read  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: w_state_nxt = r_state;
            S_FETCH: begin
                w_mem_read = (w_inflight < c_DEPTH_W);
                if (w_mem_read && !mem.mem_waitrequest && (r_issued == c_LAST)) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_vs_fall) begin
            w_state_nxt = S_FETCH;
        end
    end

    always_comb begin
        w_outst_nxt = r_outst;
        if (w_accept && !w_beat) begin
            w_outst_nxt = r_outst + c_CW'(1);
        end else if (!w_accept && w_beat) begin
            w_outst_nxt = r_outst - c_CW'(1);
        end
    end

    always_ff @(posedge clk27) begin
        if (rst27) begin
            r_vs_d      <= 1'b1;
            r_addr      <= FB_BASE;
            r_issued    <= '0;
            r_outst     <= '0;
            r_discard   <= '0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_vs_d  <= vga_vs;
            r_outst <= w_outst_nxt;
            if (w_vs_fall) begin
                // Everything still in flight, including a read accepted this very
                // cycle, belongs to the old frame and must be dropped on return.
                r_addr    <= FB_BASE;
                r_issued  <= '0;
                r_count   <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_discard <= w_outst_nxt;
            end else begin
                if (w_accept) begin
                    r_addr   <= r_addr + ADDR_W'(1);
                    r_issued <= r_issued + c_IW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CW'(1);
                end
                if (w_beat && (r_discard != '0)) begin
                    r_discard <= r_discard - c_CW'(1);
                end
            end
            if (request && w_empty) begin
                r_underflow <= 1'b1;
            end else if (underflow_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk27) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= mem.mem_readdata[29:0];
        end
    end

    assign mem.mem_read    = w_mem_read;
    assign mem.mem_address = r_addr;
    assign {r, g, b}       = w_empty ? UFLOW_RGB : r_fifo[r_rd_ptr];
    assign underflow       = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pixel_fetch
//  Description : Self-checking bench: random-stall memory slave plus a
//                frame-order reference model of the pixel stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_fetch;
    localparam int          H_ACT     = 16;
    localparam int          V_ACT     = 8;
    localparam int          FIFO_AW   = 6;
    localparam int          ADDR_W    = 24;
    localparam logic [23:0] FB_BASE   = 24'hFFFFC0;
    localparam logic [29:0] UFLOW_RGB = 30'h15A5A5A5;
    localparam int          FRAME     = H_ACT * V_ACT;
    localparam int          DEPTH     = 2**FIFO_AW;

    typedef struct {
        int          due;
        int          epoch;
        logic [23:0] addr;
        logic [29:0] val;
    } beat_t;

    logic       clk27 = 1'b0;
    logic       rst27 = 1'b1;
    logic       vga_vs = 1'b1;
    logic       request = 1'b0;
    logic       underflow_clr = 1'b0;
    logic [9:0] r, g, b;
    logic       underflow;

    vga_pixel_fetch_if #(.ADDR_W(ADDR_W)) mem_if ();

    vga_pixel_fetch #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .FIFO_AW(FIFO_AW), .ADDR_W(ADDR_W),
        .FB_BASE(FB_BASE), .UFLOW_RGB(UFLOW_RGB)
    ) dut (
        .clk27(clk27), .rst27(rst27), .vga_vs(vga_vs), .request(request),
        .r(r), .g(g), .b(b), .mem(mem_if),
        .underflow(underflow), .underflow_clr(underflow_clr)
    );

    always #5 clk27 = ~clk27;

    int checks = 0;
    int failures = 0;

    // Slave configuration and reference model state
    int          wait_pct = 0;
    int          lat = 1;
    int          beat_budget = -1;
    int          cyc = 0;
    int          epoch = 0;
    int          issued_m = 0;
    int          reads_total = 0;
    logic [23:0] last_addr = '0;
    bit          fetching = 1'b0;
    bit          vs_d_m = 1'b1;
    bit          m_uflow = 1'b0;
    bit          mon_en = 1'b0;
    beat_t       pq[$];
    logic [29:0] mq[$];

    function automatic logic [29:0] pix(input logic [23:0] a);
        return {a[9:0], ~a[9:0], a[9:0]};
    endfunction

    // Memory slave plus cycle-level scoreboard; evaluated mid-cycle and
    // advanced to the state expected after the coming clock edge.
    always @(negedge clk27) begin : mon
        bit          exp_rd, acc, beat, flush, pop;
        logic [29:0] exp_rgb;
        beat_t       e;
        if (mon_en) begin
            exp_rd = fetching && ((mq.size() + pq.size()) < DEPTH);
            checks++;
            if (mem_if.mem_read !== exp_rd) begin
                failures++;
                $display("FAIL mem_read t=%0t got=%b exp=%b", $time, mem_if.mem_read, exp_rd);
            end
            exp_rgb = (mq.size() != 0) ? mq[0] : UFLOW_RGB;
            checks++;
            if ({r, g, b} !== exp_rgb) begin
                failures++;
                $display("FAIL rgb t=%0t got=%h exp=%h", $time, {r, g, b}, exp_rgb);
            end
            checks++;
            if (underflow !== m_uflow) begin
                failures++;
                $display("FAIL underflow t=%0t got=%b exp=%b", $time, underflow, m_uflow);
            end
            if (exp_rd) begin
                checks++;
                if (mem_if.mem_address !== 24'(FB_BASE + issued_m)) begin
                    failures++;
                    $display("FAIL mem_address t=%0t got=%h exp=%h", $time,
                             mem_if.mem_address, 24'(FB_BASE + issued_m));
                end
            end
        end

        mem_if.mem_waitrequest   = ($urandom_range(0, 99) < wait_pct);
        beat = !rst27 && (pq.size() != 0) && (pq[0].due <= cyc) && (beat_budget != 0);
        mem_if.mem_readdatavalid = beat;
        mem_if.mem_readdata      = beat ? {2'b00, pix(pq[0].addr)} : $urandom();

        if (rst27) begin
            pq.delete();
            mq.delete();
            fetching = 1'b0;
            vs_d_m   = 1'b1;
            m_uflow  = 1'b0;
            issued_m = 0;
            epoch++;
        end else begin
            acc   = (mem_if.mem_read === 1'b1) && !mem_if.mem_waitrequest;
            flush = vs_d_m && !vga_vs;
            pop   = request && (mq.size() != 0);
            if (request && (mq.size() == 0)) m_uflow = 1'b1;
            else if (underflow_clr)           m_uflow = 1'b0;
            if (pop) void'(mq.pop_front());
            if (beat) begin
                e = pq.pop_front();
                if (beat_budget > 0) beat_budget--;
                if (e.epoch == epoch) mq.push_back(e.val);
            end
            if (acc) begin
                e.due   = cyc + lat;
                e.epoch = epoch;
                e.addr  = mem_if.mem_address;
                e.val   = pix(24'(FB_BASE + issued_m));
                pq.push_back(e);
                issued_m++;
                reads_total++;
                last_addr = mem_if.mem_address;
                if (issued_m == FRAME) fetching = 1'b0;
            end
            if (flush) begin
                mq.delete();
                epoch++;
                issued_m = 0;
                fetching = 1'b1;
            end
            vs_d_m = vga_vs;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk27);
        #1;
    endtask

    task automatic vs_pulse();
        vga_vs = 1'b0;
        tick();
        tick();
        vga_vs = 1'b1;
    endtask

    task automatic test_reset();
        rst27 = 1'b1;
        vga_vs = 1'b1;
        repeat (3) tick();
        rst27 = 1'b0;
        mon_en = 1'b1;
        checks++;
        if (mem_if.mem_read !== 1'b0) begin
            failures++; $display("FAIL reset_read got=%b exp=0", mem_if.mem_read);
        end
        checks++;
        if (mem_if.mem_address !== FB_BASE) begin
            failures++; $display("FAIL reset_addr got=%h exp=%h", mem_if.mem_address, FB_BASE);
        end
        checks++;
        if ({r, g, b} !== UFLOW_RGB) begin
            failures++; $display("FAIL reset_rgb got=%h exp=%h", {r, g, b}, UFLOW_RGB);
        end
        checks++;
        if (underflow !== 1'b0) begin
            failures++; $display("FAIL reset_uflow got=%b exp=0", underflow);
        end
        repeat (20) begin
            tick();
            checks++;
            if (mem_if.mem_read !== 1'b0) begin
                failures++; $display("FAIL idle_read got=%b exp=0", mem_if.mem_read);
            end
        end
    endtask

    task automatic test_prefill();
        int start;
        wait_pct = 0;
        lat = 1;
        start = reads_total;
        vs_pulse();
        repeat (100) tick();
        checks++;
        if (mem_if.mem_read !== 1'b0) begin
            failures++; $display("FAIL prefill_stop got=%b exp=0", mem_if.mem_read);
        end
        checks++;
        if (reads_total - start != DEPTH) begin
            failures++; $display("FAIL prefill_reads got=%0d exp=%0d", reads_total - start, DEPTH);
        end
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if ({r, g, b} !== pix(24'(FB_BASE + k))) begin
                failures++;
                $display("FAIL prefill_pix k=%0d got=%h exp=%h", k, {r, g, b}, pix(24'(FB_BASE + k)));
            end
            request = 1'b1;
            tick();
            request = 1'b0;
            tick();
        end
    endtask

    task automatic test_full_frame();
        int k;
        wait_pct = 30;
        lat = 3;
        vs_pulse();
        repeat (150) tick();
        k = 0;
        for (int ln = 0; ln < V_ACT; ln++) begin
            for (int px = 0; px < H_ACT; px++) begin
                checks++;
                if ({r, g, b} !== pix(24'(FB_BASE + k))) begin
                    failures++;
                    $display("FAIL frame_pix k=%0d got=%h exp=%h", k, {r, g, b}, pix(24'(FB_BASE + k)));
                end
                request = 1'b1;
                tick();
                k++;
            end
            request = 1'b0;
            repeat (8) tick();
        end
        repeat (20) tick();
        checks++;
        if (issued_m != FRAME) begin
            failures++; $display("FAIL frame_reads got=%0d exp=%0d", issued_m, FRAME);
        end
        checks++;
        if (last_addr !== 24'(FB_BASE + FRAME - 1)) begin
            failures++; $display("FAIL frame_last_addr got=%h exp=%h", last_addr, 24'(FB_BASE + FRAME - 1));
        end
        checks++;
        if (underflow !== 1'b0) begin
            failures++; $display("FAIL frame_uflow got=%b exp=0", underflow);
        end
        checks++;
        if (mem_if.mem_read !== 1'b0) begin
            failures++; $display("FAIL frame_done_read got=%b exp=0", mem_if.mem_read);
        end
    endtask

    task automatic test_underflow();
        wait_pct = 0;
        lat = 80;
        vga_vs = 1'b0;
        tick();
        vga_vs = 1'b1;
        request = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if ({r, g, b} !== UFLOW_RGB) begin
                failures++; $display("FAIL uflow_rgb got=%h exp=%h", {r, g, b}, UFLOW_RGB);
            end
        end
        request = 1'b0;
        checks++;
        if (underflow !== 1'b1) begin
            failures++; $display("FAIL uflow_set got=%b exp=1", underflow);
        end
        request = 1'b1;
        underflow_clr = 1'b1;
        tick();
        request = 1'b0;
        checks++;
        if (underflow !== 1'b1) begin
            failures++; $display("FAIL uflow_set_wins got=%b exp=1", underflow);
        end
        tick();
        underflow_clr = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin
            failures++; $display("FAIL uflow_clr got=%b exp=0", underflow);
        end
        repeat (120) tick();
        checks++;
        if ({r, g, b} !== pix(FB_BASE)) begin
            failures++; $display("FAIL uflow_late_head got=%h exp=%h", {r, g, b}, pix(FB_BASE));
        end
    endtask

    task automatic test_midframe_flush();
        int n;
        wait_pct = 0;
        lat = 20;
        vs_pulse();
        n = 0;
        while (pq.size() < 10 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (pq.size() < 10) begin
            failures++; $display("FAIL flush_setup_timeout outstanding=%0d exp=10", pq.size());
        end
        vs_pulse();
        repeat (60) tick();
        request = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({r, g, b} !== pix(24'(FB_BASE + k))) begin
                failures++;
                $display("FAIL flush_pix k=%0d got=%h exp=%h", k, {r, g, b}, pix(24'(FB_BASE + k)));
            end
            tick();
        end
        request = 1'b0;
        repeat (60) tick();
    endtask

    task automatic test_back_to_back();
        int n;
        wait_pct = 0;
        lat = 2;
        n = 0;
        while (pq.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        beat_budget = 0;
        vs_pulse();
        n = 0;
        while (mem_if.mem_read !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (mem_if.mem_read !== 1'b0) begin
            failures++; $display("FAIL b2b_window_timeout got=%b exp=0", mem_if.mem_read);
        end
        beat_budget = 1;
        tick();
        checks++;
        if ({r, g, b} !== pix(FB_BASE)) begin
            failures++; $display("FAIL b2b_one_entry got=%h exp=%h", {r, g, b}, pix(FB_BASE));
        end
        beat_budget = 1;
        request = 1'b1;
        tick();
        request = 1'b0;
        checks++;
        if ({r, g, b} !== pix(24'(FB_BASE + 1))) begin
            failures++; $display("FAIL b2b_push_pop got=%h exp=%h", {r, g, b}, pix(24'(FB_BASE + 1)));
        end
        tick();
        checks++;
        if ({r, g, b} !== pix(24'(FB_BASE + 1))) begin
            failures++; $display("FAIL b2b_hold got=%h exp=%h", {r, g, b}, pix(24'(FB_BASE + 1)));
        end
        request = 1'b1;
        tick();
        request = 1'b0;
        checks++;
        if ({r, g, b} !== UFLOW_RGB) begin
            failures++; $display("FAIL b2b_drained got=%h exp=%h", {r, g, b}, UFLOW_RGB);
        end
        beat_budget = -1;
        repeat (100) tick();
    endtask

    task automatic test_reset_midfetch();
        wait_pct = 0;
        lat = 5;
        vga_vs = 1'b0;
        tick();
        vga_vs = 1'b1;
        request = 1'b1;
        tick();
        request = 1'b0;
        repeat (4) tick();
        checks++;
        if (mem_if.mem_read !== 1'b1) begin
            failures++; $display("FAIL t6_fetching got=%b exp=1", mem_if.mem_read);
        end
        rst27 = 1'b1;
        tick();
        rst27 = 1'b0;
        checks++;
        if (mem_if.mem_read !== 1'b0 || underflow !== 1'b0 || {r, g, b} !== UFLOW_RGB) begin
            failures++;
            $display("FAIL t6_after_reset read=%b uflow=%b rgb=%h exp read=0 uflow=0 rgb=%h",
                     mem_if.mem_read, underflow, {r, g, b}, UFLOW_RGB);
        end
        repeat (30) begin
            tick();
            checks++;
            if (mem_if.mem_read !== 1'b0) begin
                failures++; $display("FAIL t6_idle got=%b exp=0", mem_if.mem_read);
            end
        end
        vs_pulse();
        checks++;
        if (mem_if.mem_read !== 1'b1) begin
            failures++; $display("FAIL t6_restart got=%b exp=1", mem_if.mem_read);
        end
        repeat (50) tick();
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_full_frame();
        test_underflow();
        test_midframe_flush();
        test_back_to_back();
        test_reset_midfetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
